// File: rtl/freq_frame_uart.sv
// freq_frame_uart
// ---------------------------------------------------------------------------
// Reads the frequency counter's byte-wide readout port after a measurement
// completes. It walks all eight {Cnt_Sel,Byte_Sel} addresses and captures
// each Freq_Data byte after a settle delay. The result is sent to the host
// as an 8N1 UART frame:
//   SYNC_HEADER, Fb[7:0..31:24], Fx[7:0..31:24] [, XOR of the 8 data bytes]
//
// Build option:
//   FRAME_CHECKSUM_EN  when defined, a checksum byte (XOR of the 8 data
//                      bytes, header excluded) is appended (10-byte frame).
//                      When undefined, the frame is 9 bytes long.
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   RST_n       in   asynchronous active-low reset
//   Finish      in   measurement-done level, asynchronous; resynchronised here
//   Send_Req    in   1-cycle retransmit request, honoured only while Finish=1
//   Freq_Data   in   [7:0] counter readout byte for the current selects
//   Cnt_Sel     out  0 = Fb reference count, 1 = Fx count
//   Byte_Sel    out  [1:0] byte lane, 0 = [7:0] .. 3 = [31:24]
//   Uart_Tx     out  serial line, idle high
//   Busy        out  high while a frame is in progress
//   Frame_Done  out  1-cycle pulse when the final stop bit completes
// ---------------------------------------------------------------------------
module freq_frame_uart #(
  parameter int         CLK_FREQ      = 50_000_000,
  parameter int         BAUD          = 115200,
  parameter logic [7:0] SYNC_HEADER   = 8'hA5,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       RST_n,
  input  logic       Finish,
  input  logic       Send_Req,
  input  logic [7:0] Freq_Data,
  output logic       Cnt_Sel,
  output logic [1:0] Byte_Sel,
  output logic       Uart_Tx,
  output logic       Busy,
  output logic       Frame_Done
);

  localparam int            BIT_CYC     = CLK_FREQ / BAUD;
  localparam int            BW          = $clog2(BIT_CYC);
  localparam logic [BW-1:0] BAUD_LAST   = BW'(BIT_CYC - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    STOP_BIT    = 4'd9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_TX = 3'd1;
  localparam logic [2:0] S_SEL    = 3'd2;
  localparam logic [2:0] S_CAP    = 3'd3;
  localparam logic [2:0] S_DAT_TX = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] S_CHK_TX = 3'd6;
`endif

  logic          sync1_q, sync2_q, sync3_q;
  logic          pend_q, pend_d;
  logic [2:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    sel_q, sel_d;
  logic [3:0]    settle_q, settle_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  logic       trig;
  logic       tx_state;
  logic       baud_end;
  logic       byte_end;
  logic [9:0] frame_w;
  logic [3:0] bit_nx;

  // Rising edge of the synchronised Finish, or a retransmit request while
  // the synchronised Finish is high.
  assign trig = (sync2_q & ~sync3_q) | (Send_Req & sync2_q);

`ifdef FRAME_CHECKSUM_EN
  assign tx_state = (state_q == S_HDR_TX) || (state_q == S_DAT_TX) ||
                    (state_q == S_CHK_TX);
`else
  assign tx_state = (state_q == S_HDR_TX) || (state_q == S_DAT_TX);
`endif

  assign baud_end = (baud_q == BAUD_LAST);
  assign byte_end = tx_state && baud_end && (bit_q == STOP_BIT);
  // Bit 0 is the start bit, bits 1..8 are data LSB first, and bit 9 is the stop bit.
  assign frame_w  = {1'b1, shreg_q, 1'b0};
  assign bit_nx   = bit_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    chk_d    = chk_q;
`endif

    // A trigger that arrives outside IDLE is remembered once. Further
    // triggers merge into the same pending request.
    if (trig && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end

    // Shared serialiser. Each bit is held for BIT_CYC clocks. The line
    // advances to the next bit when the bit's last cycle ends.
    if (tx_state) begin
      if (baud_end) begin
        baud_d = '0;
        if (bit_q != STOP_BIT) begin
          bit_d = bit_nx;
          tx_d  = frame_w[bit_nx];
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (trig || pend_q) begin
          state_d = S_HDR_TX;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          shreg_d = SYNC_HEADER;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
`ifdef FRAME_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_HDR_TX: begin
        if (byte_end) begin
          state_d  = S_SEL;
          idx_d    = 3'd0;
          sel_d    = 3'd0;
          settle_d = '0;
        end
      end
      S_SEL: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CAP;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_CAP: begin
        // Latch the byte and start its start bit on the same edge.
        state_d = S_DAT_TX;
        shreg_d = Freq_Data;
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
`ifdef FRAME_CHECKSUM_EN
        chk_d   = chk_q ^ Freq_Data;
`endif
      end
      S_DAT_TX: begin
        if (byte_end) begin
          if (idx_q != 3'd7) begin
            state_d  = S_SEL;
            idx_d    = idx_q + 3'd1;
            sel_d    = idx_q + 3'd1;
            settle_d = '0;
          end else begin
`ifdef FRAME_CHECKSUM_EN
            // The checksum follows the last stop bit with no gap.
            state_d = S_CHK_TX;
            shreg_d = chk_q;
            tx_d    = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
`else
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CHK_TX: begin
        if (byte_end) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      pend_q   <= 1'b0;
      state_q  <= S_IDLE;
      idx_q    <= '0;
      sel_q    <= '0;
      settle_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      sync1_q  <= Finish;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      pend_q   <= pend_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FRAME_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  assign Cnt_Sel    = sel_q[2];
  assign Byte_Sel   = sel_q[1:0];
  assign Uart_Tx    = tx_q;
  assign Busy       = busy_q;
  assign Frame_Done = done_q;

endmodule

// File: tb/tb_freq_frame_uart.sv
// Directed testbench for freq_frame_uart.
// Parameters: BIT_CYC = 10 and SETTLE_CYCLES = 4.
// A UART monitor decodes the line and checks the duration of each bit.
module tb_freq_frame_uart;

`ifdef FRAME_CHECKSUM_EN
  localparam int FL = 10;
`else
  localparam int FL = 9;
`endif

  logic       clk;
  logic       rst_n;
  logic       fin;
  logic       req;
  logic [7:0] fdata;
  logic       cnt_sel;
  logic [1:0] byte_sel;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;

  logic [31:0] fb, fx;

  int total = 0;
  int bad   = 0;

  // monitor-owned state
  logic [7:0] rx_q [$];
  int width_bad     = 0;
  int sel_bad       = 0;
  int low_cnt       = 0;
  int busy_cnt      = 0;
  int done_cnt      = 0;
  int done_busy_err = 0;

  int base_rx, base_done, base_busy, base_low;

  logic [7:0] exp_a [10] = '{8'hA5, 8'h80, 8'hF0, 8'hFA, 8'h02,
                             8'h80, 8'h96, 8'h98, 8'h00, 8'h06};
  logic [7:0] exp_b [10] = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};

  freq_frame_uart #(
    .CLK_FREQ      (50_000_000),
    .BAUD          (5_000_000),
    .SYNC_HEADER   (8'hA5),
    .SETTLE_CYCLES (4)
  ) dut (
    .CLOCK_50   (clk),
    .RST_n      (rst_n),
    .Finish     (fin),
    .Send_Req   (req),
    .Freq_Data  (fdata),
    .Cnt_Sel    (cnt_sel),
    .Byte_Sel   (byte_sel),
    .Uart_Tx    (uart_tx),
    .Busy       (busy),
    .Frame_Done (frame_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // counter readout mux model
  always_comb begin
    fdata = 8'h00;
    case (byte_sel)
      2'd0: fdata = cnt_sel ? fx[7:0]   : fb[7:0];
      2'd1: fdata = cnt_sel ? fx[15:8]  : fb[15:8];
      2'd2: fdata = cnt_sel ? fx[23:16] : fb[23:16];
      default: fdata = cnt_sel ? fx[31:24] : fb[31:24];
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // UART line monitor + select stability tracking
  initial begin
    logic       act;
    int         cnt;
    int         age;
    logic [2:0] prev_sel, cur;
    logic [99:0] smp;
    logic [7:0] b;
    logic       ok;
    act = 1'b0; cnt = 0; age = 0; prev_sel = 3'd0; smp = '0;
    forever begin
      @(negedge clk);
      cur = {cnt_sel, byte_sel};
      if (!rst_n) begin
        act = 1'b0;
        cnt = 0;
      end
      if (cur != prev_sel) begin
        age = 0;
        if (act) sel_bad++;
      end else begin
        age++;
      end
      prev_sel = cur;
      if (rst_n) begin
        if (!uart_tx) low_cnt++;
        if (!act) begin
          if (!uart_tx) begin
            act = 1'b1;
            cnt = 1;
            smp = '0;
            if (age < 4) sel_bad++;
          end
        end else begin
          smp[cnt] = uart_tx;
          cnt++;
          if (cnt == 100) begin
            ok = 1'b1;
            for (int k = 0; k < 10; k++)
              for (int j = 0; j < 10; j++)
                if (smp[k*10+j] != smp[k*10]) ok = 1'b0;
            if (smp[90] != 1'b1) ok = 1'b0;
            for (int i = 0; i < 8; i++) b[i] = smp[(i+1)*10];
            rx_q.push_back(b);
            if (!ok) width_bad++;
            act = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (frame_done) begin
        done_cnt++;
        if (busy) done_busy_err++;
      end
    end
  end

  task automatic snap();
    base_rx   = rx_q.size();
    base_done = done_cnt;
    base_busy = busy_cnt;
    base_low  = low_cnt;
  endtask

  task automatic pulse_req();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int cyc;
    cyc = 0;
    while ((done_cnt - base_done) < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (1300) @(negedge clk);
    check_eq(tag, done_cnt - base_done, n);
  endtask

  task automatic check_frame(input int base, input int which, input string tag);
    logic [31:0] got;
    logic [7:0]  e;
    for (int i = 0; i < FL; i++) begin
      got = (base + i < rx_q.size()) ? {24'h0, rx_q[base+i]} : 32'hDEAD;
      e   = (which == 0) ? exp_a[i] : exp_b[i];
      check_eq($sformatf("%s_byte%0d", tag, i), got, {24'h0, e});
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; fin = 1'b0; req = 1'b0;
    fb = 32'h02FAF080; fx = 32'h00989680;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", uart_tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_sel", {cnt_sel, byte_sel}, 0);
    @(negedge clk) rst_n = 1'b1;
    snap();
    repeat (1000) @(negedge clk);
    check_eq("idle_low", low_cnt - base_low, 0);
    check_eq("idle_rx", rx_q.size() - base_rx, 0);
    check_eq("idle_busy", busy_cnt - base_busy, 0);

    // basic frame + trigger-to-Busy latency
    snap();
    @(negedge clk) fin = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("lat_busy_2", busy, 0);
    @(posedge clk);
    #1 check_eq("lat_busy_3", busy, 1);
    wait_done(1, "basic_done_cnt");
    check_eq("basic_rx_cnt", rx_q.size() - base_rx, FL);
    check_frame(base_rx, 0, "basic");
    check_eq("basic_busy_end", busy, 0);

    // pending: one Send_Req mid-frame -> one extra frame
    fb = 32'h12345678; fx = 32'hDEADBEEF;
    snap();
    pulse_req();
    repeat (300) @(negedge clk);
    pulse_req();
    wait_done(2, "pend1_done_cnt");
    check_eq("pend1_rx_cnt", rx_q.size() - base_rx, 2 * FL);
    check_frame(base_rx, 1, "pend1_f0");
    check_frame(base_rx + FL, 1, "pend1_f1");

    // two pulses mid-frame coalesce
    snap();
    pulse_req();
    repeat (300) @(negedge clk);
    pulse_req();
    repeat (100) @(negedge clk);
    pulse_req();
    wait_done(2, "pend2_done_cnt");
    check_eq("pend2_rx_cnt", rx_q.size() - base_rx, 2 * FL);

    // Send_Req ignored when Finish is low
    @(negedge clk) fin = 1'b0;
    repeat (10) @(negedge clk);
    snap();
    pulse_req();
    repeat (500) @(negedge clk);
    check_eq("nofin_busy", busy_cnt - base_busy, 0);
    check_eq("nofin_rx", rx_q.size() - base_rx, 0);

    // reset during byte 4
    fb = 32'h02FAF080; fx = 32'h00989680;
    snap();
    @(negedge clk) fin = 1'b1;
    cyc = 0;
    while ((rx_q.size() - base_rx) < 4 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("mid_rx4", rx_q.size() - base_rx, 4);
    repeat (20) @(negedge clk);
    check_eq("mid_tx_low", uart_tx, 0);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", uart_tx, 1);
    check_eq("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap();
    wait_done(1, "post_rst_done_cnt");
    check_frame(base_rx, 0, "post_rst");

    check_eq("width_bad", width_bad, 0);
    check_eq("sel_bad", sel_bad, 0);
    check_eq("done_busy_err", done_busy_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
